// File: rtl/eular_pkg.sv
// Shared definitions for the Euler step control blocks: run-controller state
// encodings and the default count width shared with the Euler step counter.
package eular_pkg;

    localparam int SIZE_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/eular_down_counter.sv
// Loadable down counter holding the number of Euler steps still to issue.
// Load wins over decrement; decrement is ignored once the count reaches zero.
module eular_down_counter
    import eular_pkg::*;
#(
    parameter int Size = SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [Size-1:0] load_val,
    input  logic            dec,
    output logic [Size-1:0] cnt,
    output logic            zero
);

    logic [Size-1:0] cnt_d;
    logic [Size-1:0] cnt_q;

    // Next count: load a new budget, or step down while non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - Size'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/eular_step_countdown.sv
// Run controller for the Euler step datapath: latches a step budget on start,
// issues one step request per iteration with a one-cycle gap between requests,
// counts down on each acknowledge and pulses done when the budget is spent.
// All outputs are registered decodes of the next state, so there is no
// combinational path from any input to any output.
module eular_step_countdown
    import eular_pkg::*;
#(
    parameter int Size = SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rest_sync,
    input  logic            start,
    input  logic            abort,
    input  logic [Size-1:0] n_steps,
    input  logic            step_ack,
    output logic            step_req,
    output logic [Size-1:0] remaining,
    output logic [Size-1:0] step_idx,
    output logic            busy,
    output logic            done
);

    state_e          state_d,    state_q;
    logic [Size-1:0] step_idx_d, step_idx_q;
    logic            step_req_d, step_req_q;
    logic            busy_d,     busy_q;
    logic            done_d,     done_q;

    logic            cnt_load;
    logic            cnt_dec;
    logic [Size-1:0] cnt_val;
    logic            cnt_zero;

    eular_down_counter #(
        .Size (Size)
    ) u_remaining (
        .clk      (clk),
        .rst      (rest_sync),
        .load     (cnt_load),
        .load_val (n_steps),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .zero     (cnt_zero)
    );

    // Next-state, step index and counter controls; abort overrides start/ack.
    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        if (abort) begin
            // Counts are left as they are so the partial progress stays visible.
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_load   = 1'b1;
                        step_idx_d = '0;
                        state_d    = (n_steps != '0) ? ST_REQ : ST_DONE;
                    end
                end
                ST_REQ: begin
                    if (step_ack && !cnt_zero) begin
                        cnt_dec    = 1'b1;
                        step_idx_d = Size'(step_idx_q + 1'b1);
                        state_d    = (cnt_val == Size'(1)) ? ST_DONE : ST_GAP;
                    end
                end
                // One idle cycle so the datapath always sees a fresh request edge.
                ST_GAP:  state_d = ST_REQ;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the next state so they register alongside it.
    always_comb begin
        step_req_d = (state_d == ST_REQ);
        busy_d     = (state_d == ST_REQ) || (state_d == ST_GAP);
        done_d     = (state_d == ST_DONE);
    end

    // FSM state, step index and registered outputs with synchronous clear.
    always_ff @(posedge clk) begin
        if (rest_sync) begin
            state_q    <= ST_IDLE;
            step_idx_q <= '0;
            step_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            step_req_q <= step_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign step_req  = step_req_q;
    assign remaining = cnt_val;
    assign step_idx  = step_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_eular_step_countdown.sv
// Directed bench for the Euler step run controller: a behavioural model
// pushes expected outputs into a scoreboard each cycle, and fixed expected
// values are checked at the key points of each scenario.
module tb_eular_step_countdown;

    localparam int SZ = 6;

    logic          clk;
    logic          rest_sync;
    logic          start;
    logic          abort;
    logic [SZ-1:0] n_steps;
    logic          step_ack;
    logic          step_req;
    logic [SZ-1:0] remaining;
    logic [SZ-1:0] step_idx;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    // expected packing: {step_req, busy, done, remaining, step_idx}
    logic [2*SZ+2:0] exp_q[$];
    string           tag_q[$];

    // behavioural model: 0 idle, 1 requesting, 2 gap, 3 done
    int            m_st  = 0;
    logic [SZ-1:0] m_rem = '0;
    logic [SZ-1:0] m_idx = '0;

    eular_step_countdown #(.Size(SZ)) dut (
        .clk       (clk),
        .rest_sync (rest_sync),
        .start     (start),
        .abort     (abort),
        .n_steps   (n_steps),
        .step_ack  (step_ack),
        .step_req  (step_req),
        .remaining (remaining),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("%s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model, push its prediction, then
    // pop the prediction and compare once the DUT has clocked.
    task automatic cyc(input string tag, input logic rs, input logic st, input logic ab,
                       input logic ak, input logic [SZ-1:0] n);
        logic [2*SZ+2:0] e;
        logic [2*SZ+2:0] o;
        string           t;
        @(negedge clk);
        rest_sync = rs; start = st; abort = ab; step_ack = ak; n_steps = n;
        if (rs) begin
            m_st = 0; m_rem = '0; m_idx = '0;
        end else if (ab) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (st) begin
                       m_rem = n; m_idx = '0;
                       m_st  = (n == 0) ? 3 : 1;
                   end
                1: if (ak) begin
                       m_rem = m_rem - 1'b1;
                       m_idx = m_idx + 1'b1;
                       m_st  = (m_rem == 0) ? 3 : 2;
                   end
                2: m_st = 1;
                default: m_st = 0;
            endcase
        end
        exp_q.push_back({(m_st == 1), (m_st == 1 || m_st == 2), (m_st == 3), m_rem, m_idx});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {step_req, busy, done, remaining, step_idx};
        compare(t, 32'(o), 32'(e));
    endtask

    task automatic idle(input string tag);
        cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic ack(input string tag);
        cyc(tag, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    initial begin
        rest_sync = 1'b1; start = 1'b0; abort = 1'b0; step_ack = 1'b0; n_steps = '0;

        // power-on reset
        cyc("por", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc("por", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        compare("por_outs", 32'({step_req, busy, done, remaining, step_idx}), 32'd0);

        // normal run of three steps, ack one cycle after each request
        cyc("run3_start", 1'b0, 1'b1, 1'b0, 1'b0, 6'd3);
        compare("run3_first_req", 32'({step_req, remaining, step_idx}), 32'({1'b1, 6'd3, 6'd0}));
        ack("run3_ack1");
        compare("run3_gap1", 32'({step_req, busy, remaining, step_idx}), 32'({1'b0, 1'b1, 6'd2, 6'd1}));
        idle("run3_req2");
        ack("run3_ack2");
        idle("run3_req3");
        ack("run3_ack3");
        compare("run3_done", 32'({done, step_req, busy, remaining, step_idx}),
                32'({1'b1, 1'b0, 1'b0, 6'd0, 6'd3}));
        idle("run3_idle");
        compare("run3_hold", 32'({done, remaining, step_idx}), 32'({1'b0, 6'd0, 6'd3}));

        // reset held two cycles in the middle of a run with three steps left
        cyc("rst_start", 1'b0, 1'b1, 1'b0, 1'b0, 6'd5);
        ack("rst_ack1");
        idle("rst_req2");
        ack("rst_ack2");
        compare("rst_pre", 32'(remaining), 32'd3);
        cyc("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        cyc("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        compare("rst_outs", 32'({step_req, busy, done, remaining, step_idx}), 32'd0);
        idle("rst_after");

        // zero budget goes straight to done without a request
        cyc("zero_start", 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
        compare("zero_done", 32'({done, step_req, busy}), 32'b100);
        idle("zero_idle");
        compare("zero_idle_outs", 32'({done, step_req, busy}), 32'b000);

        // request held while the datapath withholds ack
        cyc("hold_start", 1'b0, 1'b1, 1'b0, 1'b0, 6'd2);
        for (int i = 0; i < 10; i++) idle("hold_wait");
        compare("hold_req", 32'({step_req, remaining}), 32'({1'b1, 6'd2}));
        ack("hold_ack");
        compare("hold_after_ack", 32'(remaining), 32'd1);
        idle("hold_req2");
        ack("hold_ack2");
        idle("hold_idle");

        // abort after two acks, then restart with a new budget
        cyc("abort_start", 1'b0, 1'b1, 1'b0, 1'b0, 6'd5);
        ack("abort_ack1");
        idle("abort_req2");
        ack("abort_ack2");
        cyc("abort", 1'b0, 1'b0, 1'b1, 1'b0, '0);
        compare("abort_outs", 32'({step_req, busy, done, remaining, step_idx}),
                32'({3'b000, 6'd3, 6'd2}));
        idle("abort_idle");
        cyc("abort_restart", 1'b0, 1'b1, 1'b0, 1'b0, 6'd4);
        compare("abort_restart_cnt", 32'({remaining, step_idx}), 32'({6'd4, 6'd0}));
        cyc("abort_req", 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // spurious start during a request and ack during a gap are ignored
        cyc("spur_start", 1'b0, 1'b1, 1'b0, 1'b0, 6'd3);
        cyc("spur_start_req", 1'b0, 1'b1, 1'b0, 1'b0, 6'd7);
        compare("spur_no_reload", 32'({remaining, step_idx}), 32'({6'd3, 6'd0}));
        ack("spur_ack1");
        ack("spur_ack_gap");
        compare("spur_gap_ack", 32'({step_req, remaining, step_idx}), 32'({1'b1, 6'd2, 6'd1}));
        cyc("spur_abort", 1'b0, 1'b0, 1'b1, 1'b0, '0);

        // maximum budget runs to completion
        cyc("max_start", 1'b0, 1'b1, 1'b0, 1'b0, 6'd63);
        for (int i = 0; i < 63; i++) begin
            ack("max_ack");
            if (i < 62) idle("max_gap");
        end
        compare("max_done", 32'({done, remaining, step_idx}), 32'({1'b1, 6'd0, 6'd63}));
        // abort while done is showing still returns to idle
        cyc("max_abort_done", 1'b0, 1'b0, 1'b1, 1'b0, '0);
        compare("max_idle", 32'({done, busy, remaining, step_idx}), 32'({2'b00, 6'd0, 6'd63}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
